// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and the decoded-operand record used by the ID stage.
package rv_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rs1_used;
        logic             rs2_used;
        logic             rd_wen;
        logic             is_load;
    } decode_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority bypass select for one source operand: EX > MEM > WB > register file.
module operand_fwd_mux #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] rs,
    input  logic           used,
    input  logic           ex_en,
    input  logic [RAW-1:0] ex_rd,
    input  logic [DW-1:0]  ex_data,
    input  logic           mem_en,
    input  logic [RAW-1:0] mem_rd,
    input  logic [DW-1:0]  mem_data,
    input  logic           wb_en,
    input  logic [RAW-1:0] wb_rd,
    input  logic [DW-1:0]  wb_data,
    input  logic [DW-1:0]  rf_data,
    output logic [DW-1:0]  data
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data = '0;
        if (used && rs != '0) begin
            if (ex_en && ex_rd == rs)
                data = ex_data;
            else if (mem_en && mem_rd == rs)
                data = mem_data;
            else if (wb_en && wb_rd == rs)
                data = wb_data;
            else
                data = rf_data;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-side operand fetch: register reads, EX/MEM/WB bypass, load-use stall,
// and the ID/EX pipeline register.
module id_operand_stage #(
    parameter int DW  = 32,
    parameter int RAW = 5,
    parameter int AW  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [AW-1:0]  i_pc,
    input  logic [31:0]    i_instr,
    output logic           o_rf_rd1_en,
    output logic           o_rf_rd2_en,
    output logic [RAW-1:0] o_rf_rd1,
    output logic [RAW-1:0] o_rf_rd2,
    input  logic [DW-1:0]  i_rf_data1,
    input  logic [DW-1:0]  i_rf_data2,
    input  logic [DW-1:0]  i_ex_data,
    input  logic           i_mem_valid,
    input  logic           i_mem_wen,
    input  logic [RAW-1:0] i_mem_rd,
    input  logic [DW-1:0]  i_mem_data,
    input  logic           i_wb_wen,
    input  logic [RAW-1:0] i_wb_rd,
    input  logic [DW-1:0]  i_wb_data,
    input  logic           i_flush,
    input  logic           i_ex_ready,
    output logic           o_valid,
    output logic [AW-1:0]  o_pc,
    output logic [31:0]    o_instr,
    output logic [DW-1:0]  o_rs1_data,
    output logic [DW-1:0]  o_rs2_data,
    output logic [RAW-1:0] o_rd,
    output logic           o_rd_wen,
    output logic           o_is_load,
    output logic [15:0]    o_bubble_cnt
);

    import rv_pkg::*;

    decode_t       dec;
    logic [6:0]    opcode;
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic          ex_fwd_en;
    logic          hazard;
    logic          advance;

    assign opcode = i_instr[6:0];

    always_comb begin
        dec          = '0;
        dec.rs1      = i_instr[19:15];
        dec.rs2      = i_instr[24:20];
        dec.rd       = i_instr[11:7];
        dec.rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        dec.rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        dec.rd_wen   = !(opcode == OP_STORE || opcode == OP_BRANCH) && (dec.rd != '0);
        dec.is_load  = (opcode == OP_LOAD);
    end

    assign o_rf_rd1    = dec.rs1;
    assign o_rf_rd2    = dec.rs2;
    assign o_rf_rd1_en = dec.rs1_used;
    assign o_rf_rd2_en = dec.rs2_used;

    // A load in EX has no data yet; that case is covered by the stall, not the bypass.
    assign ex_fwd_en = o_valid && o_rd_wen && !o_is_load;

    operand_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rs1 (
        .rs       (dec.rs1),
        .used     (dec.rs1_used),
        .ex_en    (ex_fwd_en),
        .ex_rd    (o_rd),
        .ex_data  (i_ex_data),
        .mem_en   (i_mem_valid && i_mem_wen),
        .mem_rd   (i_mem_rd),
        .mem_data (i_mem_data),
        .wb_en    (i_wb_wen),
        .wb_rd    (i_wb_rd),
        .wb_data  (i_wb_data),
        .rf_data  (i_rf_data1),
        .data     (rs1_val)
    );

    operand_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rs2 (
        .rs       (dec.rs2),
        .used     (dec.rs2_used),
        .ex_en    (ex_fwd_en),
        .ex_rd    (o_rd),
        .ex_data  (i_ex_data),
        .mem_en   (i_mem_valid && i_mem_wen),
        .mem_rd   (i_mem_rd),
        .mem_data (i_mem_data),
        .wb_en    (i_wb_wen),
        .wb_rd    (i_wb_rd),
        .wb_data  (i_wb_data),
        .rf_data  (i_rf_data2),
        .data     (rs2_val)
    );

    assign hazard = i_valid && o_valid && o_is_load && o_rd_wen &&
                    ((dec.rs1_used && dec.rs1 == o_rd) || (dec.rs2_used && dec.rs2 == o_rd));

    assign advance = !o_valid || i_ex_ready;
    assign o_ready = (advance && !hazard) || i_flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_instr      <= NOP_INSTR;
            o_rs1_data   <= '0;
            o_rs2_data   <= '0;
            o_rd         <= '0;
            o_rd_wen     <= 1'b0;
            o_is_load    <= 1'b0;
            o_bubble_cnt <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                // Bubble: payload is left as-is, only the valid bit drops.
                o_valid <= 1'b0;
                if (o_bubble_cnt != 16'hFFFF)
                    o_bubble_cnt <= o_bubble_cnt + 16'd1;
            end else begin
                o_valid    <= i_valid;
                o_pc       <= i_pc;
                o_instr    <= i_instr;
                o_rs1_data <= rs1_val;
                o_rs2_data <= rs2_val;
                o_rd       <= dec.rd;
                o_rd_wen   <= dec.rd_wen;
                o_is_load  <= dec.is_load;
            end
        end
    end

endmodule
